featuremap_scheduler: RTL and testbench

Sequences one convolution layer through a single time-shared featuremap engine (a bank of Conv2D3x3 instances plus adder tree). The scheduler computes each output featuremap in turn and selects that featuremap's weight set. For each pass it streams the full input map from the layer's input buffer into the engine, then writes the engine's results into the output buffer at linear addresses. It sits between the layer-level start/done handshake and the buffer/engine datapath.

---
 rtl/featuremap_sched_pkg.sv | 26 ++
 rtl/sched_counter.sv | 30 +++
 rtl/featuremap_scheduler.sv | 134 +++++++++++++
 tb/tb_featuremap_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/featuremap_sched_pkg.sv
// Shared definitions for the featuremap scheduler.
// Holds the scheduler state encoding, the per-pass pixel count and
// the helpers that derive the address and index widths from the layer geometry.
package featuremap_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    NEXT,
    DONE
  } sched_state_t;

  // Pixels in one square featuremap (one pass through the engine).
  function automatic int calc_npix(input int img_size);
    return img_size * img_size;
  endfunction

  // Bits needed to index n items. It never returns less than 1, so that a
  // single-map layer still gets a legal vector width.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_counter.sv
// Up-counter used by the featuremap scheduler.
// Ports:
//   Clk, Rst  - clock and synchronous active-high reset
//   clr       - synchronous clear; it has priority over en
//   en        - increment by one
//   count     - current value
//   tc        - high while count equals MAX
module sched_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(MAX));

endmodule

// File: rtl/featuremap_scheduler.sv
// Layer sequencer for a single time-shared featuremap engine.
// For each output featuremap the scheduler does the following in order:
//   - clears the engine
//   - streams the whole input map out of the input buffer
//   - writes every engine result to the output buffer at
//     fmap_sel*NPIX + out_cnt
// Ports:
//   Clk, Rst            - clock and synchronous active-high reset
//   start / busy / done - layer-level handshake (done is a 1-cycle pulse)
//   stall               - holds back the next input read while in FEED
//   rd_en, rd_addr      - input-buffer read port
//   feat_valid          - engine valid_in (rd_en delayed by the 1-cycle read latency)
//   eng_clear           - 1-cycle engine flush before each pass
//   fmap_sel            - weight-set select, constant across a pass
//   eng_valid           - engine valid_out, one result per pulse
//   wr_en, wr_addr      - output-buffer write port (registered)
//   err                 - sticky flag for results arriving when none are expected
module featuremap_scheduler
  import featuremap_sched_pkg::*;
#(
  parameter int IMG_SIZE  = 104,
  parameter int NUM_FMAPS = 64,
  parameter int PIX_W     = width_of(calc_npix(IMG_SIZE)),
  parameter int FMAP_W    = width_of(NUM_FMAPS),
  parameter int ADDR_W    = width_of(NUM_FMAPS * calc_npix(IMG_SIZE))
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              stall,
  output logic              rd_en,
  output logic [PIX_W-1:0]  rd_addr,
  output logic              feat_valid,
  output logic              eng_clear,
  output logic [FMAP_W-1:0] fmap_sel,
  input  logic              eng_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NPIX = calc_npix(IMG_SIZE);

  sched_state_t state_reg;

  // out_cnt must be able to hold NPIX itself, so it is one bit wider than rd_addr.
  logic [PIX_W:0] out_cnt;
  logic           rd_last;
  logic           out_full;
  logic           fmap_last;

  logic start_accept;
  logic in_pass;
  logic count_result;
  logic bad_result;
  logic pass_reset;

  assign start_accept = (state_reg == IDLE) && start;
  assign in_pass      = (state_reg == FEED) || (state_reg == DRAIN);
  assign rd_en        = (state_reg == FEED) && !stall;
  assign count_result = in_pass && eng_valid && !out_full;
  // A result is unexpected outside a pass, or once the pass already holds all NPIX results.
  assign bad_result   = eng_valid && (!in_pass || out_full);
  assign pass_reset   = start_accept || (state_reg == NEXT);

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign eng_clear = (state_reg == CLEAR);

  sched_counter #(.W(PIX_W), .MAX(NPIX - 1)) u_rd_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .clr   (pass_reset),
    .en    (rd_en),
    .count (rd_addr),
    .tc    (rd_last)
  );

  sched_counter #(.W(PIX_W + 1), .MAX(NPIX)) u_out_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .clr   (pass_reset),
    .en    (count_result),
    .count (out_cnt),
    .tc    (out_full)
  );

  sched_counter #(.W(FMAP_W), .MAX(NUM_FMAPS - 1)) u_fmap_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .clr   (start_accept),
    .en    (state_reg == NEXT),
    .count (fmap_sel),
    .tc    (fmap_last)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= IDLE;
      feat_valid <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      err        <= 1'b0;
    end else begin
      feat_valid <= rd_en;
      wr_en      <= count_result;
      if (count_result) begin
        // Widen both operands first so that fmap_sel*NPIX cannot be truncated.
        wr_addr <= ADDR_W'(fmap_sel) * ADDR_W'(NPIX) + ADDR_W'(out_cnt);
      end
      // A protocol error in the same cycle as an accepted start still gets flagged.
      if (bad_result) begin
        err <= 1'b1;
      end else if (start_accept) begin
        err <= 1'b0;
      end

      case (state_reg)
        IDLE:    if (start) state_reg <= CLEAR;
        CLEAR:   state_reg <= FEED;
        FEED:    if (rd_en && rd_last) state_reg <= DRAIN;
        // The pass ends only from DRAIN. This means that the last read is
        // always issued before the next pass starts.
        DRAIN:   if (out_full) state_reg <= fmap_last ? DONE : NEXT;
        NEXT:    state_reg <= CLEAR;
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_featuremap_scheduler.sv
// Bench for featuremap_scheduler with IMG_SIZE=4 (NPIX=16) and NUM_FMAPS=2.
// The engine is modelled as a 5-stage valid delay line. It also has an
// injection term for spurious or extra results.
module tb_featuremap_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       inject = 1'b0;
  logic       eng_valid;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       feat_valid;
  logic       eng_clear;
  logic [0:0] fmap_sel;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int n_reads = 0;
  int n_writes = 0;
  int n_clears = 0;
  int n_done = 0;
  int cyc = 0;
  int last_wr_cyc = -100;
  logic prev_rd_en = 1'b0;
  logic [4:0] pipe;

  featuremap_scheduler #(.IMG_SIZE(4), .NUM_FMAPS(2)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .start      (start),
    .stall      (stall),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .feat_valid (feat_valid),
    .eng_clear  (eng_clear),
    .fmap_sel   (fmap_sel),
    .eng_valid  (eng_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Engine model: valid_out follows valid_in by 5 cycles.
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[3:0], feat_valid};
  end
  assign eng_valid = pipe[4] | inject;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor. It runs on the falling edge and does the following:
  //   - checks that reads are sequential within each pass
  //   - checks that writes land at consecutive linear addresses
  //   - checks that feat_valid is rd_en delayed by one cycle
  //   - counts clear pulses and done pulses
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_rd_en = 1'b0;
    end else begin
      check("feat_valid_delay", 32'(feat_valid), 32'(prev_rd_en));
      if (rd_en) begin
        check("rd_addr_seq", 32'(rd_addr), 32'(n_reads % 16));
        check("rd_fmap_sel", 32'(fmap_sel), 32'(n_reads / 16));
        n_reads++;
      end
      if (wr_en) begin
        check("wr_addr_seq", 32'(wr_addr), 32'(n_writes));
        n_writes++;
        last_wr_cyc = cyc;
      end
      if (eng_clear) n_clears++;
      if (done) begin
        check("done_latency", 32'(cyc - last_wr_cyc), 32'd1);
        n_done++;
      end
      prev_rd_en = rd_en;
    end
  end

  typedef struct {
    logic       rst, start, stall, inj;
    logic       busy, clr, rd_en;
    logic [3:0] rd_addr;
    logic       fv, wr_en, err, done;
  } vec_t;

  vec_t vecs [12];

  task automatic reset_counts();
    n_reads = 0; n_writes = 0; n_clears = 0; n_done = 0;
  endtask

  // Issues start, then checks the CLEAR cycle, the first read and the first feat_valid.
  task automatic start_layer(input string tag);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({tag, "_clear"}, 32'(eng_clear), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_first_rd_en"}, 32'(rd_en), 32'd1);
    check({tag, "_first_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_first_fmap"}, 32'(fmap_sel), 32'd0);
    @(posedge clk); #1;
    check({tag, "_first_fv"}, 32'(feat_valid), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (n_done != 0) break;
    end
    check({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_totals(input string tag, input logic exp_err);
    check({tag, "_reads"}, 32'(n_reads), 32'd32);
    check({tag, "_writes"}, 32'(n_writes), 32'd32);
    check({tag, "_clears"}, 32'(n_clears), 32'd2);
    check({tag, "_dones"}, 32'(n_done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    $display("layer %s: reads=%0d writes=%0d clears=%0d dones=%0d err=%0d",
             tag, n_reads, n_writes, n_clears, n_done, err);
  endtask

  initial begin
    // Columns: rst start stall inj | busy clr rd_en rd_addr fv wr_en err done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);

    // Layer 1 opens with the table. The table covers the reset state, a
    // spurious eng_valid in IDLE, the start timing, a 1-cycle stall and an
    // ignored start.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; start = vecs[i].start; stall = vecs[i].stall; inject = vecs[i].inj;
      @(negedge clk);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_clear", i), 32'(eng_clear), 32'(vecs[i].clr));
      check($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(vecs[i].rd_en));
      check($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(vecs[i].rd_addr));
      check($sformatf("v%0d_feat_valid", i), 32'(feat_valid), 32'(vecs[i].fv));
      check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wr_en));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      $display("vec %0d: busy=%0d clr=%0d rd_en=%0d rd_addr=%0d fv=%0d err=%0d",
               i, busy, eng_clear, rd_en, rd_addr, feat_valid, err);
    end
    start = 1'b0; stall = 1'b0; inject = 1'b0;

    // Three-cycle stall just before the read of address 7.
    begin : stall_seq
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (rd_en && rd_addr == 4'd7) begin found = 1'b1; break; end
      end
      check("stall_reach_7", 32'(found), 32'd1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1;
        check("stall_rd_en", 32'(rd_en), 32'd0);
        check("stall_rd_addr", 32'(rd_addr), 32'd7);
        @(posedge clk); #1;
      end
      stall = 1'b0;
      #1;
      check("resume_rd_en", 32'(rd_en), 32'd1);
      check("resume_rd_addr", 32'(rd_addr), 32'd7);
    end
    wait_done("stall_layer");
    check_totals("stall_layer", 1'b0);

    // Nominal layer with no stalls.
    reset_counts();
    start_layer("nominal");
    wait_done("nominal");
    check_totals("nominal", 1'b0);

    // Engine emits a 17th result in pass 0. This happens in the DRAIN cycle
    // in which the count is already full.
    reset_counts();
    start_layer("extra");
    begin : extra_seq
      bit found;
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (wr_en && wr_addr == 5'd15) begin found = 1'b1; break; end
      end
      check("extra_reach_15", 32'(found), 32'd1);
      inject = 1'b1;
      @(posedge clk); #1;
      inject = 1'b0;
      check("extra_no_write", 32'(wr_en), 32'd0);
      check("extra_err_set", 32'(err), 32'd1);
    end
    wait_done("extra");
    check_totals("extra", 1'b1);

    // Reset pulse at out_cnt == 9 of pass 1 (the write to address 16+8).
    reset_counts();
    start_layer("abort");
    begin : abort_seq
      bit found;
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (wr_en && wr_addr == 5'd24) begin found = 1'b1; break; end
      end
      check("abort_reach_24", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_clear", 32'(eng_clear), 32'd0);
      check("abort_rd_en", 32'(rd_en), 32'd0);
      check("abort_rd_addr", 32'(rd_addr), 32'd0);
      check("abort_feat_valid", 32'(feat_valid), 32'd0);
      check("abort_fmap_sel", 32'(fmap_sel), 32'd0);
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_wr_addr", 32'(wr_addr), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      n_done = 0;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", 32'(n_done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      $display("abort: idle after reset, dones=%0d", n_done);
    end

    // A fresh start after the abort begins again at featuremap 0.
    reset_counts();
    start_layer("restart");
    wait_done("restart");
    check_totals("restart", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
